// File: rtl/wb_port_arbiter_if.sv
// Write-port arbiter bus: pipeline write-back, long-latency result handshake,
// decode hazard probe and the arbitrated register-file write port.
interface wb_port_arbiter_if #(
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    logic              pipe_wreg;
    logic [REG_W-1:0]  pipe_wd;
    logic [DATA_W-1:0] pipe_wdata;
    logic              lu_valid;
    logic              lu_ready;
    logic [REG_W-1:0]  lu_wd;
    logic [DATA_W-1:0] lu_wdata;
    logic [REG_W-1:0]  chk_addr;
    logic              chk_hit;
    logic              pipe_stall;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [CNT_W-1:0]  fifo_count;

    // Driver side: pipeline, long-latency unit and decode.
    modport master (
        output pipe_wreg, pipe_wd, pipe_wdata,
        output lu_valid, lu_wd, lu_wdata,
        output chk_addr,
        input  lu_ready, chk_hit, pipe_stall,
        input  rf_we, rf_waddr, rf_wdata, fifo_count
    );

    // Arbiter side.
    modport slave (
        input  pipe_wreg, pipe_wd, pipe_wdata,
        input  lu_valid, lu_wd, lu_wdata,
        input  chk_addr,
        output lu_ready, chk_hit, pipe_stall,
        output rf_we, rf_waddr, rf_wdata, fifo_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline write-back (priority)
// and a queued long-latency result stream, with a starvation-forced drain slot.
module wb_port_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    wb_port_arbiter_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned STV_W  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [REG_W-1:0]  wd;
        logic [DATA_W-1:0] wdata;
    } lu_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_t;

    lu_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic [STV_W-1:0]  starve;
    logic [STV_W-1:0]  starve_n;
    state_t            state;
    state_t            state_n;

    logic              pipe_stall;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic              non_empty;
    logic              lu_ready_c;
    logic              enq;
    logic              pipe_req;
    logic              pop;
    logic              pipe_w;
    logic              blocked;
    logic              chk_hit_c;
    logic [PTR_W-1:0]  off;

    // Port selection: a forced slot beats the pipeline, otherwise the pipeline
    // wins and the FIFO head only drains into idle cycles.
    always_comb begin
        non_empty  = (count != '0);
        lu_ready_c = (count < CNT_W'(DEPTH));
        enq        = bus.lu_valid & lu_ready_c & (bus.lu_wd != '0);
        pipe_req   = bus.pipe_wreg & (bus.pipe_wd != '0);
        pop        = non_empty & (pipe_stall | ~pipe_req);
        pipe_w     = pipe_req & ~pop;
        blocked    = non_empty & pipe_w;
    end

    always_comb begin
        count_n = count;
        if (enq && !pop) begin
            count_n = count + 1'b1;
        end else if (!enq && pop) begin
            count_n = count - 1'b1;
        end
    end

    // Starvation FSM: next state and next counter value.
    always_comb begin
        state_n  = state;
        starve_n = starve;
        unique case (state)
            IDLE: begin
                starve_n = '0;
                if (count_n != '0) begin
                    state_n = PEND;
                end
            end
            PEND: begin
                if (pop) begin
                    starve_n = '0;
                end else if (blocked) begin
                    starve_n = starve + 1'b1;
                end
                if (count_n == '0) begin
                    state_n = IDLE;
                end else if (blocked && (starve_n == STV_W'(STARVE_LIMIT))) begin
                    state_n = FORCE;
                end
            end
            FORCE: begin
                starve_n = '0;
                state_n  = (count_n != '0) ? PEND : IDLE;
            end
            default: begin
                starve_n = '0;
                state_n  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            state  <= state_n;
            starve <= starve_n;
        end
    end

    // Queue pointers, stall flag and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            pipe_stall <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            count      <= count_n;
            pipe_stall <= (state_n == FORCE);
            rf_we      <= pop | pipe_w;
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head     <= head + 1'b1;
                rf_waddr <= mem[head].wd;
                rf_wdata <= mem[head].wdata;
            end else if (pipe_w) begin
                rf_waddr <= bus.pipe_wd;
                rf_wdata <= bus.pipe_wdata;
            end
        end
    end

    // Payload storage needs no reset; validity lives in head/count.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= '{wd: bus.lu_wd, wdata: bus.lu_wdata};
        end
    end

    // Hazard probe over the occupied slots between head and head+count.
    always_comb begin
        chk_hit_c = 1'b0;
        off       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - head;
            if (({1'b0, off} < count) && (mem[PTR_W'(i)].wd == bus.chk_addr)) begin
                chk_hit_c = 1'b1;
            end
        end
        chk_hit_c = chk_hit_c & (bus.chk_addr != '0);
    end

    assign bus.lu_ready   = lu_ready_c;
    assign bus.chk_hit    = chk_hit_c;
    assign bus.pipe_stall = pipe_stall;
    assign bus.rf_we      = rf_we;
    assign bus.rf_waddr   = rf_waddr;
    assign bus.rf_wdata   = rf_wdata;
    assign bus.fifo_count = count;

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
    a_stall_has_entry: assert property (@(posedge clk) disable iff (rst) pipe_stall |-> non_empty);
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;
    localparam int unsigned DEPTH        = 2;
    localparam int unsigned STARVE_LIMIT = 4;

    typedef struct {
        logic [4:0]  wd;
        logic [31:0] wdata;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    ent_t        q[$];
    int          run;
    bit          m_stall;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    // Comb outputs observed in the most recent step.
    logic obs_hit;
    logic obs_ready;
    int   stall_cycles;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit model_hit(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].wd == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input bit r, input bit wreg, input logic [4:0] wd,
                              input logic [31:0] wdata, input bit lv,
                              input logic [4:0] lwd, input logic [31:0] lwdata);
        bit   had;
        bit   full;
        bit   req;
        bit   pop;
        ent_t e;
        if (r) begin
            q.delete();
            run = 0; m_stall = 0; m_we = 0; m_addr = '0; m_data = '0;
            return;
        end
        had  = (q.size() != 0);
        full = (q.size() >= DEPTH);
        req  = wreg && (wd != 5'd0);
        pop  = had && (m_stall || !req);
        if (pop) begin
            e = q.pop_front();
            m_we = 1; m_addr = e.wd; m_data = e.wdata;
        end else if (req) begin
            m_we = 1; m_addr = wd; m_data = wdata;
        end else begin
            m_we = 0;
        end
        if (lv && !full && lwd != 5'd0) begin
            e.wd = lwd; e.wdata = lwdata;
            q.push_back(e);
        end
        // A head that stayed queued this cycle lost the port to the pipeline.
        if (!had || pop) run = 0;
        else run++;
        m_stall = (run == STARVE_LIMIT);
    endtask

    task automatic step(input bit r, input bit wreg, input logic [4:0] wd,
                        input logic [31:0] wdata, input bit lv, input logic [4:0] lwd,
                        input logic [31:0] lwdata, input logic [4:0] ca);
        rst = r;
        bus.pipe_wreg = wreg; bus.pipe_wd = wd; bus.pipe_wdata = wdata;
        bus.lu_valid = lv; bus.lu_wd = lwd; bus.lu_wdata = lwdata;
        bus.chk_addr = ca;
        #1;
        obs_hit   = bus.chk_hit;
        obs_ready = bus.lu_ready;
        chk("lu_ready", 32'(bus.lu_ready), 32'(q.size() < DEPTH));
        chk("chk_hit", 32'(bus.chk_hit), 32'(model_hit(ca)));
        @(posedge clk);
        model_edge(r, wreg, wd, wdata, lv, lwd, lwdata);
        #1;
        chk("rf_we", 32'(bus.rf_we), 32'(m_we));
        chk("rf_waddr", 32'(bus.rf_waddr), 32'(m_addr));
        chk("rf_wdata", bus.rf_wdata, m_data);
        chk("pipe_stall", 32'(bus.pipe_stall), 32'(m_stall));
        chk("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
    endtask

    task automatic idle(input logic [4:0] ca);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, ca);
    endtask

    initial begin
        rst = 1'b1;
        bus.pipe_wreg = 0; bus.pipe_wd = '0; bus.pipe_wdata = '0;
        bus.lu_valid = 0; bus.lu_wd = '0; bus.lu_wdata = '0; bus.chk_addr = '0;
        run = 0; m_stall = 0; m_we = 0; m_addr = '0; m_data = '0;

        // Reset state
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);
        chk("rst_we", 32'(bus.rf_we), 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_ready", 32'(bus.lu_ready), 32'd1);

        // Priority and latency
        idle(5'd0);
        step(0, 1, 5'd5, 32'hDEAD0001, 1, 5'd7, 32'h77, 5'd0);
        chk("t1_addr0", 32'(bus.rf_waddr), 32'd5);
        chk("t1_data0", bus.rf_wdata, 32'hDEAD0001);
        chk("t1_cnt1", 32'(bus.fifo_count), 32'd1);
        idle(5'd0);
        chk("t1_addr1", 32'(bus.rf_waddr), 32'd7);
        chk("t1_data1", bus.rf_wdata, 32'h77);
        chk("t1_cnt0", 32'(bus.fifo_count), 32'd0);

        // x0 drop
        step(0, 1, 5'd0, 32'h1234, 0, 5'd0, 32'd0, 5'd0);
        chk("t2_we_pipe", 32'(bus.rf_we), 32'd0);
        step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h55, 5'd0);
        chk("t2_we_lu", 32'(bus.rf_we), 32'd0);
        chk("t2_cnt", 32'(bus.fifo_count), 32'd0);
        chk("t2_ready", 32'(bus.lu_ready), 32'd1);

        // Full FIFO
        step(0, 1, 5'd3, 32'h30, 1, 5'd1, 32'h11, 5'd0);
        step(0, 1, 5'd4, 32'h40, 1, 5'd2, 32'h22, 5'd0);
        chk("t3_cnt", 32'(bus.fifo_count), 32'd2);
        chk("t3_ready", 32'(bus.lu_ready), 32'd0);
        step(0, 1, 5'd6, 32'h60, 1, 5'd3, 32'h33, 5'd0);
        chk("t3_noacc", 32'(bus.fifo_count), 32'd2);
        repeat (4) idle(5'd0);

        // Starvation
        step(0, 1, 5'd3, 32'h3, 1, 5'd9, 32'h99, 5'd0);
        stall_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 5'(10 + k), 32'(k), 0, 5'd0, 32'd0, 5'd0);
            if (k == 3) chk("t4_stall", 32'(bus.pipe_stall), 32'd1);
            if (k == 4) begin
                chk("t4_addr", 32'(bus.rf_waddr), 32'd9);
                chk("t4_unstall", 32'(bus.pipe_stall), 32'd0);
            end
            if (bus.pipe_stall) stall_cycles++;
        end
        chk("t4_once", 32'(stall_cycles), 32'd1);

        // Hazard probe
        step(0, 1, 5'd3, 32'h3, 1, 5'd12, 32'hC, 5'd0);
        step(0, 1, 5'd4, 32'h4, 0, 5'd0, 32'd0, 5'd12);
        chk("t5_hit", 32'(obs_hit), 32'd1);
        step(0, 1, 5'd4, 32'h4, 0, 5'd0, 32'd0, 5'd0);
        chk("t5_hit0", 32'(obs_hit), 32'd0);
        idle(5'd12);
        idle(5'd12);
        chk("t5_popped", 32'(obs_hit), 32'd0);

        // Reset mid-operation with a forced slot pending
        step(0, 1, 5'd3, 32'h3, 1, 5'd20, 32'h20, 5'd0);
        step(0, 1, 5'd4, 32'h4, 1, 5'd21, 32'h21, 5'd0);
        for (int k = 0; k < 10 && !bus.pipe_stall; k++)
            step(0, 1, 5'd5, 32'h5, 0, 5'd0, 32'd0, 5'd0);
        chk("t6_stall_seen", 32'(bus.pipe_stall), 32'd1);
        chk("t6_cnt2", 32'(bus.fifo_count), 32'd2);
        step(1, 1, 5'd5, 32'h5, 0, 5'd0, 32'd0, 5'd0);
        chk("t6_cnt", 32'(bus.fifo_count), 32'd0);
        chk("t6_stall", 32'(bus.pipe_stall), 32'd0);
        chk("t6_we", 32'(bus.rf_we), 32'd0);
        chk("t6_ready", 32'(bus.lu_ready), 32'd1);
        repeat (3) begin
            idle(5'd0);
            chk("t6_nowrite", 32'(bus.rf_we), 32'd0);
        end

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)),
                 $urandom,
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 7)),
                 $urandom,
                 5'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
